// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcode encodings,
// FSM state type and a few sizing constants used by the stage and its ALU.
package exe_pkg;

    localparam int OP_W = 4;
    localparam int RD_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADDU = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SUBU = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_MUL  = 4'd8
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_w.sv
// Single-cycle combinational datapath of the execute stage. Produces the
// WIDTH-bit result, signed overflow for ADD/SUB, and a flag telling whether
// the opcode is one this ALU implements (reserved codes yield zero).
module alu_w
    import exe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OP_W-1:0]  i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_legal
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    logic             w_sltu;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_slt  = $signed(i_a) < $signed(i_b);
    assign w_sltu = i_a < i_b;

    // Select the result for the current opcode; overflow only for signed add/sub.
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_legal    = 1'b1;
        case (i_op)
            OP_ADDU: o_result = w_sum;
            OP_ADD: begin
                o_result   = w_sum;
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUBU: o_result = w_diff;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_sltu};
            default: o_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage. Single-cycle ALU ops land in the output
// register one cycle after acceptance; MUL runs a one-bit-per-cycle
// shift-add multiplier for WIDTH cycles before writing the output register.
// The output register has its own valid bit and a ready/valid handshake.
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic [OP_W-1:0]  In_Op,
    input  logic             In_RegWr,
    input  logic [RD_W-1:0]  In_Rd,
    input  logic             Flush,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Result,
    output logic             Out_Zero,
    output logic             Out_Overflow,
    output logic             Out_RegWr,
    output logic [RD_W-1:0]  Out_Rd,
    output logic             Busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    // Counter value at which the final multiplier step is performed.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    // Counter value meaning "all steps done, waiting for output space".
    localparam logic [CNT_W-1:0] DONE_ITER = CNT_W'(WIDTH);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             r_mulRegWr;
    logic [RD_W-1:0]  r_mulRd;
    logic             r_busy;

    logic             r_outValid;
    logic [WIDTH-1:0] r_outResult;
    logic             r_outZero;
    logic             r_outOvf;
    logic             r_outRegWr;
    logic [RD_W-1:0]  r_outRd;

    logic             w_outSpace;
    logic             w_inReady;
    logic             w_accept;
    logic             w_isMul;
    logic [OP_W-1:0]  w_aluOp;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluOvf;
    logic             w_aluLegal;
    logic             w_aluRegWr;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_mulFinal;
    logic             w_mulDone;

    // Output register is free if empty or being consumed this cycle.
    assign w_outSpace = ~r_outValid | Out_Ready;
    assign w_inReady  = (r_state == ST_IDLE) & ~Flush & w_outSpace;
    assign w_accept   = In_Valid & w_inReady;

    // With the multiplier compiled out, MUL is executed as ADDU.
    assign w_isMul = (MUL_EN != 0) && (In_Op == OP_MUL);
    assign w_aluOp = ((MUL_EN == 0) && (In_Op == OP_MUL)) ? OP_ADDU : In_Op;

    alu_w #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_a       (In_A),
        .i_b       (In_B),
        .i_op      (w_aluOp),
        .o_result  (w_aluResult),
        .o_overflow(w_aluOvf),
        .o_legal   (w_aluLegal)
    );

    assign w_aluRegWr = In_RegWr & w_aluLegal & ~w_aluOvf;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier bit is set.
    assign w_partial = r_mplier[0] ? r_mcand : '0;
    assign w_accNext = r_acc + w_partial;

    // If the final step already ran while stalled, the product sits in r_acc.
    assign w_mulFinal = (r_count == DONE_ITER) ? r_acc : w_accNext;
    assign w_mulDone  = (r_state == ST_MUL) && (r_count >= LAST_ITER) && w_outSpace;

    // Control FSM and iterative multiplier; Flush aborts any MUL in progress.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_mulRegWr <= 1'b0;
            r_mulRd    <= '0;
            r_busy     <= 1'b0;
        end else if (Flush) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_isMul) begin
                        r_state    <= ST_MUL;
                        r_busy     <= 1'b1;
                        r_count    <= '0;
                        r_mcand    <= In_A;
                        r_mplier   <= In_B;
                        r_acc      <= '0;
                        r_mulRegWr <= In_RegWr;
                        r_mulRd    <= In_Rd;
                    end
                end
                ST_MUL: begin
                    if (w_mulDone) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_count <= '0;
                    end else if (r_count < DONE_ITER) begin
                        r_acc    <= w_accNext;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: loaded by a finishing MUL or an accepted ALU op,
    // emptied when consumed or flushed, otherwise held unchanged.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_outValid  <= 1'b0;
            r_outResult <= '0;
            r_outZero   <= 1'b0;
            r_outOvf    <= 1'b0;
            r_outRegWr  <= 1'b0;
            r_outRd     <= '0;
        end else if (Flush) begin
            r_outValid <= 1'b0;
        end else if (w_mulDone) begin
            r_outValid  <= 1'b1;
            r_outResult <= w_mulFinal;
            r_outZero   <= (w_mulFinal == '0);
            r_outOvf    <= 1'b0;
            r_outRegWr  <= r_mulRegWr;
            r_outRd     <= r_mulRd;
        end else if (w_accept && !w_isMul) begin
            r_outValid  <= 1'b1;
            r_outResult <= w_aluResult;
            r_outZero   <= (w_aluResult == '0);
            r_outOvf    <= w_aluOvf;
            r_outRegWr  <= w_aluRegWr;
            r_outRd     <= In_Rd;
        end else if (Out_Ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign In_Ready     = w_inReady;
    assign Out_Valid    = r_outValid;
    assign Out_Result   = r_outResult;
    assign Out_Zero     = r_outZero;
    assign Out_Overflow = r_outOvf;
    assign Out_RegWr    = r_outRegWr;
    assign Out_Rd       = r_outRd;
    assign Busy         = r_busy;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: directed corner cases followed by
// random traffic, all checked against a cycle-level behavioural model.
// A second WIDTH=16 instance covers reset in the middle of a multiply.
module tb_exe_stage_mc;

    typedef struct {
        logic [31:0] res;
        bit          zero;
        bit          ovf;
        bit          regwr;
        logic [4:0]  rd;
    } exp_t;

    localparam longint MAX_S32 = 64'sd2147483647;
    localparam longint MIN_S32 = -64'sd2147483648;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [3:0]  inOp;
    logic        inRegWr;
    logic [4:0]  inRd;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic        outZero;
    logic        outOverflow;
    logic        outRegWr;
    logic [4:0]  outRd;
    logic        busy;

    logic        sReset;
    logic        sInValid;
    logic        sInReady;
    logic [15:0] sInA;
    logic [15:0] sInB;
    logic [3:0]  sInOp;
    logic        sInRegWr;
    logic [4:0]  sInRd;
    logic        sFlush;
    logic        sOutValid;
    logic        sOutReady;
    logic [15:0] sOutResult;
    logic        sOutZero;
    logic        sOutOverflow;
    logic        sOutRegWr;
    logic [4:0]  sOutRd;
    logic        sBusy;

    int checkCount = 0;
    int errCount   = 0;

    // Model state: output register occupancy/contents and pending multiply.
    bit   mFull;
    exp_t mOut;
    bit   mMulPending;
    int   mMulIter;
    exp_t mMulExp;

    exe_stage_mc #(.WIDTH(32), .MUL_EN(1)) u_dut (
        .Clk(clk), .Reset(reset), .In_Valid(inValid), .In_Ready(inReady),
        .In_A(inA), .In_B(inB), .In_Op(inOp), .In_RegWr(inRegWr), .In_Rd(inRd),
        .Flush(flush), .Out_Valid(outValid), .Out_Ready(outReady),
        .Out_Result(outResult), .Out_Zero(outZero), .Out_Overflow(outOverflow),
        .Out_RegWr(outRegWr), .Out_Rd(outRd), .Busy(busy)
    );

    exe_stage_mc #(.WIDTH(16), .MUL_EN(1)) u_dut16 (
        .Clk(clk), .Reset(sReset), .In_Valid(sInValid), .In_Ready(sInReady),
        .In_A(sInA), .In_B(sInB), .In_Op(sInOp), .In_RegWr(sInRegWr), .In_Rd(sInRd),
        .Flush(sFlush), .Out_Valid(sOutValid), .Out_Ready(sOutReady),
        .Out_Result(sOutResult), .Out_Zero(sOutZero), .Out_Overflow(sOutOverflow),
        .Out_RegWr(sOutRegWr), .Out_Rd(sOutRd), .Busy(sBusy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Architectural result of one operation, straight from the opcode table.
    function automatic exp_t refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input bit rw, input logic [4:0] rd);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        bit          legal;
        sa      = longint'($signed(a));
        sb      = longint'($signed(b));
        e.res   = '0;
        e.ovf   = 1'b0;
        e.rd    = rd;
        legal   = 1'b1;
        case (op)
            4'd0: e.res = a + b;
            4'd1: begin
                s     = sa + sb;
                e.res = s[31:0];
                e.ovf = (s > MAX_S32) || (s < MIN_S32);
            end
            4'd2: begin
                s     = sa - sb;
                e.res = s[31:0];
                e.ovf = (s > MAX_S32) || (s < MIN_S32);
            end
            4'd3: e.res = a - b;
            4'd4: e.res = a & b;
            4'd5: e.res = a | b;
            4'd6: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8: begin
                p     = {32'b0, a} * {32'b0, b};
                e.res = p[31:0];
            end
            default: legal = 1'b0;
        endcase
        e.zero  = (e.res == 32'd0);
        e.regwr = rw && legal && !e.ovf;
        return e;
    endfunction

    // Drive one cycle of inputs on the 32-bit DUT, advance the model across
    // the clock edge and compare handshake and output register.
    task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit rw, input logic [4:0] rd,
                                 input bit ordy, input bit fl);
        bit   expReady;
        bit   accepted;
        bit   space;
        exp_t e;
        inValid  = v;
        inOp     = op;
        inA      = a;
        inB      = b;
        inRegWr  = rw;
        inRd     = rd;
        outReady = ordy;
        flush    = fl;
        #1;
        expReady = !mMulPending && !fl && (!mFull || ordy);
        checkOutput("in_ready", inReady, expReady);
        accepted = v && expReady;
        @(posedge clk);
        space = !mFull || ordy;
        if (fl) begin
            mFull       = 1'b0;
            mMulPending = 1'b0;
        end else begin
            if (mFull && ordy) mFull = 1'b0;
            if (mMulPending) begin
                mMulIter++;
                if (mMulIter >= 32 && space) begin
                    mFull       = 1'b1;
                    mOut        = mMulExp;
                    mMulPending = 1'b0;
                end
            end else if (accepted) begin
                e = refModel(op, a, b, rw, rd);
                if (op == 4'd8) begin
                    mMulPending = 1'b1;
                    mMulIter    = 0;
                    mMulExp     = e;
                end else begin
                    mFull = 1'b1;
                    mOut  = e;
                end
            end
        end
        #1;
        checkOutput("out_valid", outValid, mFull);
        checkOutput("busy", busy, mMulPending);
        if (mFull) begin
            checkOutput("out_result", outResult, mOut.res);
            checkOutput("out_zero", outZero, mOut.zero);
            checkOutput("out_overflow", outOverflow, mOut.ovf);
            checkOutput("out_regwr", outRegWr, mOut.regwr);
            checkOutput("out_rd", outRd, mOut.rd);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          busyCnt;
        int          seen;
        int          sel;
        logic [3:0]  rOp;

        reset = 1'b1; inValid = 1'b0; inA = '0; inB = '0; inOp = '0;
        inRegWr = 1'b0; inRd = '0; flush = 1'b0; outReady = 1'b1;
        sReset = 1'b1; sInValid = 1'b0; sInA = '0; sInB = '0; sInOp = '0;
        sInRegWr = 1'b0; sInRd = '0; sFlush = 1'b0; sOutReady = 1'b1;
        mFull = 1'b0; mMulPending = 1'b0; mMulIter = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", outValid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_result", outResult, 32'd0);
        checkOutput("rst_zero", outZero, 1'b0);
        checkOutput("rst_ovf", outOverflow, 1'b0);
        checkOutput("rst_regwr", outRegWr, 1'b0);
        checkOutput("rst_rd", outRd, 5'd0);
        reset  = 1'b0;
        sReset = 1'b0;

        // Signed overflow on ADD suppresses the register write
        applyStimulus(1, 4'd1, 32'h7FFF_FFFF, 32'd1, 1, 5'd3, 1, 0);
        checkOutput("add_ovf_result", outResult, 32'h8000_0000);
        checkOutput("add_ovf_flag", outOverflow, 1'b1);
        checkOutput("add_ovf_regwr", outRegWr, 1'b0);

        applyStimulus(1, 4'd2, 32'd5, 32'd5, 1, 5'd4, 1, 0);
        checkOutput("sub_zero_result", outResult, 32'd0);
        checkOutput("sub_zero_flag", outZero, 1'b1);
        checkOutput("sub_zero_regwr", outRegWr, 1'b1);
        applyStimulus(1, 4'd6, 32'hFFFF_FFFF, 32'd1, 1, 5'd5, 1, 0);
        checkOutput("slt_result", outResult, 32'd1);
        applyStimulus(1, 4'd7, 32'hFFFF_FFFF, 32'd1, 1, 5'd6, 1, 0);
        checkOutput("sltu_result", outResult, 32'd0);
        applyStimulus(1, 4'd12, 32'h1234, 32'h5678, 1, 5'd7, 1, 0);
        checkOutput("reserved_result", outResult, 32'd0);
        checkOutput("reserved_regwr", outRegWr, 1'b0);

        // Multiply: Busy for 32 cycles, ADD offered meanwhile is refused
        applyStimulus(1, 4'd8, 32'h0001_2345, 32'h0000_0100, 1, 5'd8, 1, 0);
        busyCnt = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (outValid) break;
            applyStimulus(1, 4'd0, 32'd1, 32'd1, 1, 5'd1, 1, 0);
            if (busy) busyCnt++;
        end
        checkOutput("mul_busy_cycles", busyCnt, 32);
        checkOutput("mul_result", outResult, 32'h0123_4500);

        applyStimulus(1, 4'd8, 32'hFFFF_FFFF, 32'd2, 1, 5'd9, 1, 0);
        for (int i = 0; i < 40; i++) begin
            if (outValid) break;
            applyStimulus(0, 4'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0);
        end
        checkOutput("mul_wrap_result", outResult, 32'hFFFF_FFFE);

        // Back-pressure: held result stays put, then ADD enters as it drains
        applyStimulus(1, 4'd0, 32'd1, 32'd2, 1, 5'd10, 1, 0);
        applyStimulus(1, 4'd0, 32'd10, 32'd20, 1, 5'd11, 0, 0);
        checkOutput("hold_ready", inReady, 1'b0);
        checkOutput("hold_result", outResult, 32'd3);
        applyStimulus(1, 4'd0, 32'd10, 32'd20, 1, 5'd11, 1, 0);
        checkOutput("drain_accept_result", outResult, 32'd30);

        // Flush at iteration 10 of a multiply, with a same-cycle offer
        applyStimulus(1, 4'd8, 32'd7, 32'd9, 1, 5'd12, 1, 0);
        repeat (10) applyStimulus(0, 4'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0);
        applyStimulus(1, 4'd0, 32'd1, 32'd1, 1, 5'd13, 1, 1);
        checkOutput("flush_busy", busy, 1'b0);
        checkOutput("flush_valid", outValid, 1'b0);
        repeat (3) applyStimulus(0, 4'd0, 32'd0, 32'd0, 0, 5'd0, 1, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 16)       rOp = 4'(sel % 8);
            else if (sel == 16) rOp = 4'd8;
            else                rOp = 4'($urandom_range(9, 15));
            applyStimulus($urandom_range(0, 3) != 0, rOp, pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end

        // WIDTH=16 instance: reset in the middle of a multiply
        @(posedge clk);
        #1;
        sInValid = 1'b1; sInOp = 4'd8; sInA = 16'hFFFF; sInB = 16'd3; sInRegWr = 1'b1; sInRd = 5'd17;
        @(posedge clk);
        #1;
        sInValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("r16_busy_before", sBusy, 1'b1);
        #2;
        sReset = 1'b1;
        #1;
        checkOutput("r16_valid", sOutValid, 1'b0);
        checkOutput("r16_busy", sBusy, 1'b0);
        checkOutput("r16_result", sOutResult, 16'd0);
        checkOutput("r16_zero", sOutZero, 1'b0);
        checkOutput("r16_ovf", sOutOverflow, 1'b0);
        checkOutput("r16_regwr", sOutRegWr, 1'b0);
        checkOutput("r16_rd", sOutRd, 5'd0);
        @(posedge clk);
        #1;
        sReset = 1'b0;
        #1;
        checkOutput("r16_ready_after", sInReady, 1'b1);
        seen = 0;
        repeat (24) begin
            @(posedge clk);
            #1;
            if (sOutValid || sBusy) seen++;
        end
        checkOutput("r16_no_result", seen, 0);
        sInValid = 1'b1; sInOp = 4'd0; sInA = 16'd3; sInB = 16'd4; sInRegWr = 1'b1; sInRd = 5'd9;
        @(posedge clk);
        #1;
        sInValid = 1'b0;
        checkOutput("r16_addu_valid", sOutValid, 1'b1);
        checkOutput("r16_addu_result", sOutResult, 16'd7);
        checkOutput("r16_addu_rd", sOutRd, 5'd9);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
